// File: rtl/dct_coef_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dct_coef_engine                                                            |
// | One 2D DCT coefficient per ACC command (pixels x basis term), or a raster  |
// | dump of the N x N basis terms per DUMP command.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dct_coef_engine #(
  parameter int N     = 8,
  parameter int FRAC  = 10,
  parameter int PIX_W = 9,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  localparam int LOG2N = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [LOG2N-1:0]        i_cmd_k1,
  input  logic [LOG2N-1:0]        i_cmd_k2,
  input  logic                    i_cmd_mode,
  input  logic                    i_pix_valid,
  output logic                    o_pix_ready,
  input  logic signed [PIX_W-1:0] i_pix_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic signed [OUT_W-1:0] o_out_coef,
  output logic [LOG2N-1:0]        o_out_k1,
  output logic [LOG2N-1:0]        o_out_k2,
  output logic                    o_out_last
);

  localparam int BW = FRAC + 2;        // 1D basis entry width
  localparam int TW = 2 * BW - FRAC;   // 2D term width after the rounding shift
  localparam int PW = PIX_W + TW;      // pixel x term product width
  localparam int IW = 2 * LOG2N;
  localparam logic [IW-1:0] c_IDX_LAST = '1;
  localparam real c_PI = 3.14159265358979323846;

  localparam logic signed [2*BW-1:0] c_T_HALF =
    {{(2*BW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] c_ACC_HALF =
    {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] c_OMAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_OMIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // cos(m*pi/(2N)) by Taylor series after folding the angle into [-pi, pi]
  function automatic real f_cos_q(input int m);
    int  mm;
    real x;
    real term;
    real sum;
    mm = m % (4 * N);
    if (mm > 2 * N) mm = mm - 4 * N;
    x    = $itor(mm) * c_PI / $itor(2 * N);
    sum  = 1.0;
    term = 1.0;
    for (int i = 1; i <= 24; i++) begin
      term = -term * x * x / $itor((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real f_sqrt(input real v);
    real r;
    r = 1.0;
    for (int i = 0; i < 40; i++) r = 0.5 * (r + v / r);
    return r;
  endfunction

  function automatic logic [N*N*BW-1:0] f_rom();
    logic [N*N*BW-1:0] rom;
    real a;
    real x;
    int  v;
    rom = '0;
    for (int k = 0; k < N; k++) begin
      a = (k == 0) ? f_sqrt(1.0 / $itor(N)) : f_sqrt(2.0 / $itor(N));
      for (int n = 0; n < N; n++) begin
        x = $itor(1 << FRAC) * a * f_cos_q((2 * n + 1) * k);
        v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        rom[(k*N+n)*BW +: BW] = v[BW-1:0];
      end
    end
    return rom;
  endfunction

  localparam logic [N*N*BW-1:0] c_ROM = f_rom();

  function automatic logic signed [BW-1:0] f_basis(input logic [LOG2N-1:0] k,
                                                   input logic [LOG2N-1:0] n);
    return c_ROM[int'({k, n})*BW +: BW];
  endfunction

  function automatic logic signed [OUT_W-1:0] f_sat(input logic signed [ACC_W-1:0] v);
    if (v > c_OMAX) return c_OMAX[OUT_W-1:0];
    if (v < c_OMIN) return c_OMIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC   = 3'd1,
    S_FLUSH = 3'd2,
    S_OUT   = 3'd3,
    S_DUMP  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LOG2N-1:0]        r_k1;
  logic [LOG2N-1:0]        r_k2;
  logic [IW-1:0]           r_idx;
  logic [1:0]              r_flush;
  logic signed [PW-1:0]    r_p;
  logic                    r_p_vld;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [OUT_W-1:0] r_coef;

  logic                    w_cmd_acc;
  logic                    w_pix_acc;
  logic [LOG2N-1:0]        w_n1;
  logic [LOG2N-1:0]        w_n2;
  logic signed [BW-1:0]    w_b1;
  logic signed [BW-1:0]    w_b2;
  logic signed [2*BW-1:0]  w_bprod;
  logic signed [2*BW-1:0]  w_bsum;
  logic signed [TW-1:0]    w_term;
  logic signed [ACC_W-1:0] w_term_ext;
  logic signed [PW-1:0]    w_pix_prod;
  logic signed [ACC_W-1:0] w_p_ext;
  logic signed [ACC_W-1:0] w_acc_rnd;
  logic signed [ACC_W-1:0] w_acc_shr;
  logic signed [OUT_W-1:0] w_sat_acc;
  logic signed [OUT_W-1:0] w_sat_term;

  assign w_cmd_acc = i_cmd_valid & o_cmd_ready;
  assign w_pix_acc = i_pix_valid & o_pix_ready;
  assign w_n1      = r_idx[IW-1:LOG2N];
  assign w_n2      = r_idx[LOG2N-1:0];
  assign w_b1      = f_basis(r_k1, w_n1);
  assign w_b2      = f_basis(r_k2, w_n2);

  // Operands are sign-extended to full width so the low product bits are exact
  assign w_bprod    = {{BW{w_b1[BW-1]}}, w_b1} * {{BW{w_b2[BW-1]}}, w_b2};
  assign w_bsum     = w_bprod + c_T_HALF;
  assign w_term     = w_bsum[2*BW-1:FRAC];
  assign w_term_ext = {{(ACC_W-TW){w_term[TW-1]}}, w_term};
  assign w_pix_prod = {{TW{i_pix_data[PIX_W-1]}}, i_pix_data} *
                      {{PIX_W{w_term[TW-1]}}, w_term};
  assign w_p_ext    = {{(ACC_W-PW){r_p[PW-1]}}, r_p};
  assign w_acc_rnd  = r_acc + c_ACC_HALF;
  assign w_acc_shr  = w_acc_rnd >>> FRAC;
  assign w_sat_acc  = f_sat(w_acc_shr);
  assign w_sat_term = f_sat(w_term_ext);

  assign o_out_k1 = r_k1;
  assign o_out_k2 = r_k2;

  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    o_pix_ready = 1'b0;
    o_out_valid = 1'b0;
    o_out_coef  = r_coef;
    o_out_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_state_nxt = i_cmd_mode ? S_DUMP : S_ACC;
      end
      S_ACC: begin
        o_pix_ready = 1'b1;
        if (i_pix_valid && (r_idx == c_IDX_LAST)) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_flush == 2'd2) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        o_out_valid = 1'b1;
        o_out_last  = 1'b1;
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      S_DUMP: begin
        o_out_valid = 1'b1;
        o_out_coef  = w_sat_term;
        o_out_last  = (r_idx == c_IDX_LAST);
        if (i_out_ready && (r_idx == c_IDX_LAST)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FLUSH spans two drain cycles plus one cycle forming the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k1    <= '0;
      r_k2    <= '0;
      r_idx   <= '0;
      r_flush <= '0;
      r_p     <= '0;
      r_p_vld <= 1'b0;
      r_acc   <= '0;
      r_coef  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_p_vld <= w_pix_acc;
      if (w_pix_acc) r_p <= w_pix_prod;
      if (r_p_vld) r_acc <= r_acc + w_p_ext;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_acc) begin
            r_k1    <= i_cmd_k1;
            r_k2    <= i_cmd_k2;
            r_idx   <= '0;
            r_acc   <= '0;
            r_flush <= '0;
          end
        end
        S_ACC: begin
          if (w_pix_acc) r_idx <= r_idx + IW'(1);
        end
        S_FLUSH: begin
          r_flush <= r_flush + 2'd1;
          if (r_flush == 2'd2) r_coef <= w_sat_acc;
        end
        S_DUMP: begin
          if (i_out_ready) r_idx <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dct_coef_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dct_coef_engine                                                         |
// | Bench for dct_coef_engine at OUT_W=16 and OUT_W=11 against a real-math     |
// | reference of the DCT basis, plus hand-computed anchor values.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dct_coef_engine;

  localparam int N     = 8;
  localparam int FRAC  = 10;
  localparam int PIX_W = 9;
  localparam int ACC_W = 32;
  localparam int NN    = N * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset       = 1'b1;
  logic              i_cmd_valid = 1'b0;
  logic [2:0]        i_cmd_k1    = '0;
  logic [2:0]        i_cmd_k2    = '0;
  logic              i_cmd_mode  = 1'b0;
  logic              i_pix_valid = 1'b0;
  logic signed [8:0] i_pix_data  = '0;
  logic              i_out_ready = 1'b1;

  logic               o_cmd_ready, o_pix_ready, o_out_valid, o_out_last;
  logic signed [15:0] o_out_coef;
  logic [2:0]         o_out_k1, o_out_k2;
  logic               o11_cmd_ready, o11_pix_ready, o11_out_valid, o11_out_last;
  logic signed [10:0] o11_out_coef;
  logic [2:0]         o11_out_k1, o11_out_k2;

  dct_coef_engine #(.N(N), .FRAC(FRAC), .PIX_W(PIX_W), .ACC_W(ACC_W), .OUT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_k1(i_cmd_k1), .i_cmd_k2(i_cmd_k2), .i_cmd_mode(i_cmd_mode),
    .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready), .i_pix_data(i_pix_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_coef(o_out_coef),
    .o_out_k1(o_out_k1), .o_out_k2(o_out_k2), .o_out_last(o_out_last)
  );

  dct_coef_engine #(.N(N), .FRAC(FRAC), .PIX_W(PIX_W), .ACC_W(ACC_W), .OUT_W(11)) u_dut11 (
    .clk(clk), .reset(reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o11_cmd_ready),
    .i_cmd_k1(i_cmd_k1), .i_cmd_k2(i_cmd_k2), .i_cmd_mode(i_cmd_mode),
    .i_pix_valid(i_pix_valid), .o_pix_ready(o11_pix_ready), .i_pix_data(i_pix_data),
    .o_out_valid(o11_out_valid), .i_out_ready(i_out_ready), .o_out_coef(o11_out_coef),
    .o_out_k1(o11_out_k1), .o_out_k2(o11_out_k2), .o_out_last(o11_out_last)
  );

  int checks   = 0;
  int failures = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: held low

  typedef struct {
    longint     val;
    logic [2:0] k1;
    logic [2:0] k2;
    logic       last;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference basis straight from the cosine definition
  function automatic int m_basis(input int k, input int n);
    real a, c, x;
    a = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
    c = $cos($itor((2 * n + 1) * k) * 3.141592653589793 / $itor(2 * N));
    x = a * c * $itor(1 << FRAC);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic longint m_term(input int k1, input int k2, input int idx);
    longint p;
    p = longint'(m_basis(k1, idx / N)) * longint'(m_basis(k2, idx % N)) + (1 << (FRAC - 1));
    return p >>> FRAC;
  endfunction

  function automatic longint m_round(input longint sum);
    return (sum + (1 << (FRAC - 1))) >>> FRAC;
  endfunction

  function automatic longint m_sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       i_out_ready = 1'b1;
      1:       i_out_ready = 1'($urandom_range(0, 1));
      default: i_out_ready = 1'b0;
    endcase
  end

  // Output scoreboard and hold-stability monitor
  logic               prev_hold = 1'b0;
  logic signed [15:0] prev_coef = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", longint'(o_out_valid), 1);
        chk("hold_coef", longint'(o_out_coef), longint'(prev_coef));
      end
      if (o_out_valid && i_out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("beat_coef16", longint'(o_out_coef), m_sat(e.val, 16));
          chk("beat_coef11", longint'(o11_out_coef), m_sat(e.val, 11));
          chk("beat_valid11", longint'(o11_out_valid), 1);
          chk("beat_k1", longint'(o_out_k1), longint'(e.k1));
          chk("beat_k2", longint'(o_out_k2), longint'(e.k2));
          chk("beat_last", longint'(o_out_last), longint'(e.last));
        end
      end
      prev_hold = o_out_valid && !i_out_ready;
      prev_coef = o_out_coef;
    end
  end

  task automatic send_cmd(input logic [2:0] k1, input logic [2:0] k2, input logic mode);
    bit ok = 1'b0;
    int n  = 0;
    i_cmd_k1 = k1; i_cmd_k2 = k2; i_cmd_mode = mode; i_cmd_valid = 1'b1;
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = o_cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    i_cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 0, 1);
  endtask

  // val < -256 selects random pixels
  task automatic send_pixels(input int k1, input int k2, input int count, input int val,
                             input int bubble_pct, output longint sum);
    logic [31:0] r;
    sum = 0;
    for (int i = 0; i < count; i++) begin
      while ($urandom_range(0, 99) < bubble_pct) begin
        i_pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      r = (val < -256) ? $urandom : val;
      i_pix_data  = r[8:0];
      i_pix_valid = 1'b1;
      begin
        bit ok = 1'b0;
        int n  = 0;
        while (!ok && n < 400) begin
          @(negedge clk);
          ok = o_pix_ready;
          @(posedge clk); #1;
          n++;
        end
        if (!ok) chk("pix_accept_timeout", 0, 1);
      end
      sum += longint'(i_pix_data) * m_term(k1, k2, i);
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic run_acc(input logic [2:0] k1, input logic [2:0] k2, input int val,
                         input int bubble_pct);
    longint sum;
    exp_t e;
    send_cmd(k1, k2, 1'b0);
    send_pixels(k1, k2, NN, val, bubble_pct, sum);
    e.val = m_round(sum); e.k1 = k1; e.k2 = k2; e.last = 1'b1;
    q.push_back(e);
  endtask

  task automatic run_dump(input logic [2:0] k1, input logic [2:0] k2);
    exp_t e;
    for (int i = 0; i < NN; i++) begin
      e.val = m_term(k1, k2, i); e.k1 = k1; e.k2 = k2; e.last = (i == NN - 1);
      q.push_back(e);
    end
    send_cmd(k1, k2, 1'b1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!o_out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while ((q.size() != 0 || !o_cmd_ready) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4000) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat;
    longint junk;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", longint'(o_out_valid), 0);
    chk("rst_out_coef", longint'(o_out_coef), 0);
    chk("rst_out_k1", longint'(o_out_k1), 0);
    chk("rst_out_k2", longint'(o_out_k2), 0);
    chk("rst_out_last", longint'(o_out_last), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", longint'(o_cmd_ready), 1);
    chk("post_rst_pix_ready", longint'(o_pix_ready), 0);
    @(posedge clk); #1;

    // DUMP (7,2) with hand-computed anchor terms
    run_dump(3'd7, 3'd2);
    for (int b = 0; b < NN; b++) begin
      @(negedge clk);
      chk("dump_valid", longint'(o_out_valid), 1);
      chk("dump_last", longint'(o_out_last), longint'(b == NN - 1));
      chk("dump_pix_ready", longint'(o_pix_ready), 0);
      case (b)
        0:       chk("dump_idx0", longint'(o_out_coef), 46);
        1:       chk("dump_idx1", longint'(o_out_coef), 19);
        2:       chk("dump_idx2", longint'(o_out_coef), -19);
        8:       chk("dump_idx8", longint'(o_out_coef), -131);
        default: ;
      endcase
    end
    @(negedge clk);
    chk("dump_cmd_ready_after", longint'(o_cmd_ready), 1);
    @(posedge clk); #1;

    // ACC (0,0), 64 x 100, no bubbles: latency and DC value
    run_acc(3'd0, 3'd0, 100, 0);
    wait_valid(lat);
    chk("acc_latency", lat, 3);
    chk("acc_dc_coef", longint'(o_out_coef), 800);
    chk("acc_dc_k1", longint'(o_out_k1), 0);
    chk("acc_dc_k2", longint'(o_out_k2), 0);
    chk("acc_dc_last", longint'(o_out_last), 1);
    wait_idle();

    // ACC (7,2) of a flat block
    run_acc(3'd7, 3'd2, 100, 0);
    wait_valid(lat);
    chk("acc_72_coef", longint'(o_out_coef), 0);
    chk("acc_72_k1", longint'(o_out_k1), 7);
    chk("acc_72_k2", longint'(o_out_k2), 2);
    wait_idle();

    // Bubbles plus a 5-cycle output stall
    ready_mode = 2;
    run_acc(3'd0, 3'd0, 100, 30);
    wait_valid(lat);
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      chk("stall_valid", longint'(o_out_valid), 1);
      chk("stall_coef", longint'(o_out_coef), 800);
      chk("stall_cmd_ready", longint'(o_cmd_ready), 0);
      chk("stall_pix_ready", longint'(o_pix_ready), 0);
    end
    ready_mode = 0;
    wait_idle();

    // Reset after 30 pixels, then a clean block
    send_cmd(3'd0, 3'd0, 1'b0);
    send_pixels(0, 0, 30, 100, 0, junk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", longint'(o_out_valid), 0);
    chk("abort_cmd_ready", longint'(o_cmd_ready), 1);
    @(posedge clk); #1;
    run_acc(3'd0, 3'd0, 100, 0);
    wait_valid(lat);
    chk("abort_fresh_coef", longint'(o_out_coef), 800);
    wait_idle();

    // Saturation at the narrow output width
    run_acc(3'd0, 3'd0, 255, 0);
    wait_valid(lat);
    chk("sat_coef16", longint'(o_out_coef), 2040);
    chk("sat_coef11", longint'(o11_out_coef), 1023);
    wait_idle();

    // Randomized commands, pixels, bubbles and backpressure
    ready_mode = 1;
    for (int t = 0; t < 14; t++) begin
      logic [2:0] k1, k2;
      k1 = 3'($urandom_range(0, 7));
      k2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) run_dump(k1, k2);
      else                           run_acc(k1, k2, -1000, 20);
    end
    wait_idle();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    chk("queue_drained", longint'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dct_coef_engine.md
# dct_coef_engine

- Parametrised 2D DCT coefficient engine for one N×N block.
- Accepts a command (k1, k2, mode) and then does one of two things:
  - accumulates N×N streamed pixels against the cosine basis term for (k1, k2), or
  - dumps the N×N basis terms themselves.
- Replaces the per-(k1,k2) hard-coded cosine LUTs with one runtime-indexed basis ROM.
- Sits between the pixel-block buffer and the coefficient quantiser in the DCT path.

## Interface
- N, 8: block size; power of two, 4..16; LOG2N = $clog2(N).
- FRAC, 10: fraction bits of basis terms.
- PIX_W, 9: signed pixel width (level-shifted samples).
- ACC_W, 32: signed accumulator width.
- OUT_W, 16: signed output width.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle, command accepted on valid&ready.
- cmd_k1  in  LOG2N  vertical frequency index.
- cmd_k2  in  LOG2N  horizontal frequency index.
- cmd_mode  in  1  0 = DCT accumulate, 1 = basis dump.
- pix_valid  in  1  pixel offered.
- pix_ready  out  1  pixel accepted on valid&ready.
- pix_data  in  PIX_W  signed pixel, raster order (n1 major, n2 minor).
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts.
- out_coef  out  OUT_W  signed coefficient or basis term.
- out_k1, out_k2  out  LOG2N  echo of command indices.
- out_last  out  1  final beat of the command.

## Operation
- 1D basis ROM B[k][n] = round(2^FRAC · α(k) · cos((2n+1)kπ/(2N))).
  - α(0) = √(1/N); α(k>0) = √(2/N).
  - Contents are computed by a constant function at elaboration.
  - Each entry is signed, FRAC+2 bits.
- 2D term T(n1,n2) = (B[k1][n1] · B[k2][n2] + 2^(FRAC−1)) >>> FRAC.
  - Arithmetic shift; halves round toward +∞.
- Counter idx runs 0..N²−1, with n1 = idx[2·LOG2N−1:LOG2N] and n2 = idx[LOG2N−1:0].
- FSM states: IDLE → (cmd_valid) → ACC or DUMP → FLUSH (ACC only) → OUT → IDLE.
- IDLE:
  - cmd_ready = 1.
  - On acceptance, latch k1, k2 and mode; idx ← 0; acc ← 0.
- ACC:
  - pix_ready = 1 while idx < N².
  - Each accepted pixel advances idx.
  - Stage 1 registers p = pix_data · T(idx).
  - Stage 2 does acc += p.
  - After the pixel with idx = N²−1 is accepted, go to FLUSH.
- FLUSH:
  - Two cycles to drain the pipeline.
  - Then out_coef = saturate_OUTW((acc + 2^(FRAC−1)) >>> FRAC); out_last = 1; go to OUT.
- DUMP:
  - pix_ready = 0.
  - out_valid = 1; out_coef = T(idx) sign-extended; out_last = (idx == N²−1).
  - idx advances on out_valid & out_ready.
  - Go to IDLE after the last beat is accepted.
- OUT: hold out_valid and all out_* until out_ready, then go to IDLE.
- Saturation clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. The accumulator itself does not wrap at the default widths.
- Pixel bubbles (pix_valid low) do not advance the pipeline state and do not corrupt acc.
- reset asserted in any state, mid-block included:
  - Next state is IDLE.
  - idx, acc and pipeline valids are cleared; in-flight pixels are discarded.

## Timing
- Reset values (registered): out_valid 0, out_coef 0, out_k1/out_k2 0, out_last 0, state IDLE.
- cmd_ready and pix_ready are combinational from state.
- In the cycle after reset deasserts, cmd_ready = 1 and pix_ready = 0.
- cmd_ready is 0 from the command-accept cycle until the cycle after the final out handshake.
- A back-to-back command is therefore accepted one cycle after the final out handshake.
- ACC latency: out_valid rises 3 cycles after the clock edge accepting the last pixel.
  - Throughput is one pixel per cycle with no bubbles.
  - Minimum command-to-result time is N² + 3 cycles.
- DUMP:
  - First term is valid in the cycle after command acceptance.
  - One term per cycle while out_ready = 1.
- out_valid never drops without an out_ready handshake, except on reset.

## Test plan
- Reset, then DUMP with k1=7, k2=2 (N=8, FRAC=10):
  - beats idx0 = 46, idx1 = 19, idx2 = −19, idx8 = −131;
  - 64 beats total; out_last only on beat 63; cmd_ready returns 1 one cycle after the last handshake.
- ACC with k1=0, k2=0 and 64 pixels of 100, no bubbles:
  - out_coef = 800, out_k1 = out_k2 = 0, out_last = 1;
  - out_valid exactly 3 cycles after the last pixel edge.
- ACC with k1=7, k2=2 and 64 pixels of 100 → out_coef = 0.
- Same ACC (0,0) with random pix_valid bubbles and out_ready held low for 5 cycles:
  - out_coef = 800, stable across the stall;
  - cmd_ready = 0 and pix_ready = 0 throughout the stall.
- Reset asserted after 30 pixels of an ACC command:
  - next cycle out_valid = 0 and cmd_ready = 1;
  - a fresh ACC (0,0) with 64 pixels of 100 yields 800, with no residue from the aborted block.
- ACC (0,0) with 64 pixels of 255:
  - out_coef = 2040;
  - with OUT_W = 11, the output saturates to 1023.
